multi_issue_decode: RTL and testbench

- Parametrised N-wide decode stage for the superscalar front end. Sits between fetch and the issue/register-read stage.
- Takes a fetch bundle of ISSUE_W instructions. Decodes every lane into the standard control bundle (Jump, Branch, MemWrite, ALUSrc, RegWrite, ResultSrc, TargetSrc, ImmSrc, ALUControl).
- Splits the bundle into dependency-free issue groups and hands them on through a registered valid/ready interface.

---
 rtl/multi_decode_pkg.sv | 72 +++++++
 rtl/lane_decoder.sv | 126 ++++++++++++
 rtl/multi_issue_decode.sv | 198 +++++++++++++++++++
 tb/tb_multi_issue_decode.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_decode_pkg.sv
// Shared types and encodings for the multi-issue decode stage: opcodes, ALU and
// immediate selectors, and the packed per-lane control bundle.
package multi_decode_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLTU  = 4'b0110;
    localparam logic [3:0] ALU_SLL   = 4'b0111;
    localparam logic [3:0] ALU_SRL   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [1:0] TGT_PCIMM = 2'b00;
    localparam logic [1:0] TGT_ALU   = 2'b01;
    localparam logic [1:0] TGT_NONE  = 2'b10;

    typedef struct packed {
        logic       jump;
        logic       branch;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] target_src;
        logic [2:0] imm_src;
        logic [3:0] alu_ctrl;
    } ctrl_t;

    localparam ctrl_t CTRL_RST = ctrl_t'{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RES_ALU, TGT_NONE,
                                         IMM_I, ALU_ADD};

    // alt selects SUB/SRA; callers only assert it where funct7[5] is meaningful.
    function automatic logic [3:0] alu_from_funct(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/lane_decoder.sv
// Combinational single-instruction decoder: control bundle, source-use flags,
// memory-access flag and illegal-encoding flag.
module lane_decoder
    import multi_decode_pkg::*;
(
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o,
    output logic        use_rs1_o,
    output logic        use_rs2_o,
    output logic        is_mem_o,
    output logic        illegal_o
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       legal;
    ctrl_t      ctrl;
    logic       use_rs1;
    logic       use_rs2;
    logic       is_mem;
    logic       unused_fields;

    assign opcode        = instr_i[6:0];
    assign f3            = instr_i[14:12];
    assign f7            = instr_i[31:25];
    assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

    always_comb begin
        ctrl    = CTRL_RST;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        is_mem  = 1'b0;
        legal   = 1'b1;
        case (opcode)
            OP_R: begin
                legal = (f7 == 7'b0000000) ||
                        (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
                ctrl.reg_write = 1'b1;
                ctrl.alu_ctrl  = alu_from_funct(f3, f7[5]);
                use_rs1        = 1'b1;
                use_rs2        = 1'b1;
            end
            OP_I: begin
                if (f3 == 3'b001) begin
                    legal = (f7 == 7'b0000000);
                end else if (f3 == 3'b101) begin
                    legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                end
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = alu_from_funct(f3, (f3 == 3'b101) && f7[5]);
                use_rs1        = 1'b1;
            end
            OP_LOAD: begin
                legal = !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_MEM;
                use_rs1         = 1'b1;
                is_mem          = 1'b1;
            end
            OP_STORE: begin
                legal = (f3 <= 3'b010);
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.imm_src   = IMM_S;
                use_rs1        = 1'b1;
                use_rs2        = 1'b1;
                is_mem         = 1'b1;
            end
            OP_BRANCH: begin
                legal = !(f3 == 3'b010 || f3 == 3'b011);
                ctrl.branch     = 1'b1;
                ctrl.imm_src    = IMM_B;
                ctrl.target_src = TGT_PCIMM;
                ctrl.alu_ctrl   = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
                use_rs1         = 1'b1;
                use_rs2         = 1'b1;
            end
            OP_JAL: begin
                ctrl.jump       = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_PC4;
                ctrl.imm_src    = IMM_J;
                ctrl.target_src = TGT_PCIMM;
            end
            OP_JALR: begin
                legal = (f3 == 3'b000);
                ctrl.jump       = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_PC4;
                ctrl.target_src = TGT_ALU;
                use_rs1         = 1'b1;
            end
            OP_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.imm_src   = IMM_U;
                ctrl.alu_ctrl  = ALU_PASSB;
            end
            OP_AUIPC: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.imm_src   = IMM_U;
            end
            default: legal = 1'b0;
        endcase

        // Illegal lanes collapse to a NOP so they never create hazards.
        if (!legal) begin
            ctrl    = CTRL_RST;
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
            is_mem  = 1'b0;
        end
    end

    assign ctrl_o    = ctrl;
    assign use_rs1_o = use_rs1;
    assign use_rs2_o = use_rs2;
    assign is_mem_o  = is_mem;
    assign illegal_o = !legal;

endmodule

// File: rtl/multi_issue_decode.sv
// N-wide decode stage: holds a fetch bundle and issues it as dependency-free groups.
// Optional MID_ILLEGAL_TRAP_EN adds per-lane illegal flags and ends a bundle at an illegal lane.
module multi_issue_decode
    import multi_decode_pkg::*;
#(
    parameter int unsigned ISSUE_W = 2,
    parameter int unsigned CTRL_W  = 16
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    flush_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [ISSUE_W*32-1:0]   in_instr_i,
    input  logic [ISSUE_W-1:0]      in_lane_valid_i,
    input  logic [31:0]             in_pc_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [ISSUE_W-1:0]      out_lane_valid_o,
    output logic [ISSUE_W*CTRL_W-1:0] out_ctrl_o,
    output logic [ISSUE_W*15-1:0]   out_regs_o,
    output logic [ISSUE_W*32-1:0]   out_pc_o,
`ifdef MID_ILLEGAL_TRAP_EN
    output logic [ISSUE_W-1:0]      out_illegal_o,
`endif
    output logic                    out_split_o
);

    logic [31:0]              instr_q [ISSUE_W];
    logic [31:0]              instr_d [ISSUE_W];
    logic [31:0]              pc_q, pc_d;
    logic [ISSUE_W-1:0]       pend_q, pend_d;
    logic                     out_valid_q, out_valid_d;
    logic [ISSUE_W-1:0]       out_mask_q, out_mask_d;
    logic [ISSUE_W*CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
    logic [ISSUE_W*15-1:0]    out_regs_q, out_regs_d;
    logic [ISSUE_W*32-1:0]    out_pc_q, out_pc_d;
    logic                     out_split_q, out_split_d;

    ctrl_t                    lane_ctrl [ISSUE_W];
    logic [ISSUE_W-1:0]       lane_rs1, lane_rs2, lane_mem, lane_illegal;
    logic [ISSUE_W-1:0]       group_mask, rem_mask;
    logic                     kill;
    logic                     advance, accept;

    for (genvar g = 0; g < ISSUE_W; g++) begin : g_lane
        lane_decoder u_dec (
            .instr_i   (instr_q[g]),
            .ctrl_o    (lane_ctrl[g]),
            .use_rs1_o (lane_rs1[g]),
            .use_rs2_o (lane_rs2[g]),
            .is_mem_o  (lane_mem[g]),
            .illegal_o (lane_illegal[g])
        );
    end

    // Group = longest hazard-free run of pending lanes starting at the lowest one.
    always_comb begin
        logic [31:0] wr_set;
        logic        has_mem, prev_bj, open, started, conflict;
        group_mask = '0;
        kill       = 1'b0;
        wr_set     = '0;
        has_mem    = 1'b0;
        prev_bj    = 1'b0;
        open       = 1'b1;
        started    = 1'b0;
        conflict   = 1'b0;
        for (int i = 0; i < int'(ISSUE_W); i++) begin
            if (open && pend_q[i]) begin
                conflict = 1'b0;
                if (started) begin
                    conflict = (lane_rs1[i] && wr_set[instr_q[i][19:15]]) ||
                               (lane_rs2[i] && wr_set[instr_q[i][24:20]]) ||
                               (lane_mem[i] && has_mem) || prev_bj;
                end
                if (conflict) begin
                    open = 1'b0;
                end else begin
                    group_mask[i] = 1'b1;
                    started       = 1'b1;
                    if (lane_ctrl[i].reg_write && instr_q[i][11:7] != 5'd0) begin
                        wr_set[instr_q[i][11:7]] = 1'b1;
                    end
                    has_mem = has_mem | lane_mem[i];
                    prev_bj = lane_ctrl[i].jump | lane_ctrl[i].branch;
`ifdef MID_ILLEGAL_TRAP_EN
                    if (lane_illegal[i]) begin
                        open = 1'b0;
                        kill = 1'b1;
                    end
`endif
                end
            end else if (started) begin
                open = 1'b0;
            end
        end
    end

`ifndef MID_ILLEGAL_TRAP_EN
    logic unused_illegal;
    assign unused_illegal = ^lane_illegal;
`endif

    assign rem_mask   = kill ? '0 : (pend_q & ~group_mask);
    assign advance    = !out_valid_q || out_ready_i;
    assign in_ready_o = !flush_i && (pend_q == '0 || (advance && rem_mask == '0));
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        instr_d     = instr_q;
        pc_d        = pc_q;
        pend_d      = pend_q;
        out_valid_d = out_valid_q;
        out_mask_d  = out_mask_q;
        out_ctrl_d  = out_ctrl_q;
        out_regs_d  = out_regs_q;
        out_pc_d    = out_pc_q;
        out_split_d = out_split_q;
        if (flush_i) begin
            pend_d      = '0;
            out_valid_d = 1'b0;
        end else begin
            if (advance) begin
                if (pend_q != '0) begin
                    out_valid_d = 1'b1;
                    out_mask_d  = group_mask;
                    out_split_d = (rem_mask != '0);
                    pend_d      = rem_mask;
                    for (int i = 0; i < int'(ISSUE_W); i++) begin
                        out_ctrl_d[i*CTRL_W +: CTRL_W] = group_mask[i] ? lane_ctrl[i] : CTRL_RST;
                        out_regs_d[i*15 +: 15] = {instr_q[i][11:7], instr_q[i][24:20],
                                                  instr_q[i][19:15]};
                        out_pc_d[i*32 +: 32]   = pc_q + 32'(i) * 32'd4;
                    end
                end else begin
                    out_valid_d = 1'b0;
                end
            end
            // Accept is only possible when the hold register drains this edge.
            if (accept) begin
                for (int i = 0; i < int'(ISSUE_W); i++) begin
                    instr_d[i] = in_instr_i[i*32 +: 32];
                end
                pc_d   = in_pc_i;
                pend_d = in_lane_valid_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < int'(ISSUE_W); i++) begin
                instr_q[i] <= '0;
            end
            pc_q        <= '0;
            pend_q      <= '0;
            out_valid_q <= 1'b0;
            out_mask_q  <= '0;
            out_ctrl_q  <= {ISSUE_W{CTRL_RST}};
            out_regs_q  <= '0;
            out_pc_q    <= '0;
            out_split_q <= 1'b0;
        end else begin
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            out_mask_q  <= out_mask_d;
            out_ctrl_q  <= out_ctrl_d;
            out_regs_q  <= out_regs_d;
            out_pc_q    <= out_pc_d;
            out_split_q <= out_split_d;
        end
    end

`ifdef MID_ILLEGAL_TRAP_EN
    logic [ISSUE_W-1:0] out_illegal_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            out_illegal_q <= '0;
        end else if (!flush_i && advance && pend_q != '0) begin
            out_illegal_q <= group_mask & lane_illegal;
        end
    end

    assign out_illegal_o = out_illegal_q;
`endif

    assign out_valid_o      = out_valid_q;
    assign out_lane_valid_o = out_mask_q;
    assign out_ctrl_o       = out_ctrl_q;
    assign out_regs_o       = out_regs_q;
    assign out_pc_o         = out_pc_q;
    assign out_split_o      = out_split_q;

endmodule

// File: tb/tb_multi_issue_decode.sv
// Directed bench for multi_issue_decode (ISSUE_W=2): grouping, hazards, backpressure,
// flush and asynchronous reset, against hand-computed expected values.
module tb_multi_issue_decode;
    import multi_decode_pkg::*;

    localparam int unsigned IW = 2;

    localparam logic [31:0] ADDI_X1   = 32'h00500093;
    localparam logic [31:0] ADD_X2_34 = 32'h00418133;
    localparam logic [31:0] ADD_X2_11 = 32'h00108133;
    localparam logic [31:0] ADDI_X0   = 32'h00100013;
    localparam logic [31:0] ADD_X2_00 = 32'h00000133;
    localparam logic [31:0] LW_X1     = 32'h00012083;
    localparam logic [31:0] LW_X3     = 32'h00412183;

    logic                 clk_i = 1'b0;
    logic                 rstn_i;
    logic                 flush_i;
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [IW*32-1:0]     in_instr_i;
    logic [IW-1:0]        in_lane_valid_i;
    logic [31:0]          in_pc_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [IW-1:0]        out_lane_valid_o;
    logic [IW*16-1:0]     out_ctrl_o;
    logic [IW*15-1:0]     out_regs_o;
    logic [IW*32-1:0]     out_pc_o;
    logic                 out_split_o;
`ifdef MID_ILLEGAL_TRAP_EN
    logic [IW-1:0]        out_illegal_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    multi_issue_decode #(.ISSUE_W(IW), .CTRL_W(16)) dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .flush_i          (flush_i),
        .in_valid_i       (in_valid_i),
        .in_ready_o       (in_ready_o),
        .in_instr_i       (in_instr_i),
        .in_lane_valid_i  (in_lane_valid_i),
        .in_pc_i          (in_pc_i),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .out_lane_valid_o (out_lane_valid_o),
        .out_ctrl_o       (out_ctrl_o),
        .out_regs_o       (out_regs_o),
        .out_pc_o         (out_pc_o),
`ifdef MID_ILLEGAL_TRAP_EN
        .out_illegal_o    (out_illegal_o),
`endif
        .out_split_o      (out_split_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [15:0] mk(input logic j, input logic b, input logic mw,
                                       input logic as, input logic rw, input logic [1:0] res,
                                       input logic [1:0] tgt, input logic [2:0] imm,
                                       input logic [3:0] alu);
        return {j, b, mw, as, rw, res, tgt, imm, alu};
    endfunction

    function automatic logic [15:0] ctrl_lane(input int k);
        return out_ctrl_o[k*16 +: 16];
    endfunction

    function automatic logic [14:0] regs_lane(input int k);
        return out_regs_o[k*15 +: 15];
    endfunction

    function automatic logic [31:0] pc_lane(input int k);
        return out_pc_o[k*32 +: 32];
    endfunction

    task automatic send(input logic [31:0] i0, input logic [31:0] i1, input logic [1:0] lv,
                        input logic [31:0] pc);
        in_instr_i      = {i1, i0};
        in_lane_valid_i = lv;
        in_pc_i         = pc;
        in_valid_i      = 1'b1;
        check("accept_ready", in_ready_o, 1'b1);
        step();
        in_valid_i = 1'b0;
    endtask

    logic [15:0] c_nop, c_addi, c_add, c_lw;

    initial begin
        c_nop  = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b000, 4'b0000);
        c_addi = mk(0, 0, 0, 1, 1, 2'b00, 2'b10, 3'b000, 4'b0000);
        c_add  = mk(0, 0, 0, 0, 1, 2'b00, 2'b10, 3'b000, 4'b0000);
        c_lw   = mk(0, 0, 0, 1, 1, 2'b01, 2'b10, 3'b000, 4'b0000);

        rstn_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        in_instr_i = '0; in_lane_valid_i = '0; in_pc_i = '0;
        #12;
        check("rst_valid", out_valid_o, 1'b0);
        check("rst_mask", out_lane_valid_o, 2'b00);
        check("rst_split", out_split_o, 1'b0);
        check("rst_ctrl0", ctrl_lane(0), c_nop);
        check("rst_ctrl1", ctrl_lane(1), c_nop);
        check("rst_regs", out_regs_o, '0);
        check("rst_pc", out_pc_o, '0);
        rstn_i = 1'b1;
        #1;
        check("rst_ready", in_ready_o, 1'b1);

        // Independent bundle: one group, valid two edges after accept.
        send(ADDI_X1, ADD_X2_34, 2'b11, 32'h100);
        check("ind_valid_e1", out_valid_o, 1'b0);
        check("ind_ready_e1", in_ready_o, 1'b1);
        step();
        check("ind_valid", out_valid_o, 1'b1);
        check("ind_mask", out_lane_valid_o, 2'b11);
        check("ind_split", out_split_o, 1'b0);
        check("ind_ctrl0", ctrl_lane(0), c_addi);
        check("ind_ctrl1", ctrl_lane(1), c_add);
        check("ind_regs0", regs_lane(0), {5'd1, 5'd5, 5'd0});
        check("ind_regs1", regs_lane(1), {5'd2, 5'd4, 5'd3});
        check("ind_pc0", pc_lane(0), 32'h100);
        check("ind_pc1", pc_lane(1), 32'h104);
        step();
        check("ind_drain", out_valid_o, 1'b0);

        // RAW on x1: two groups.
        send(ADDI_X1, ADD_X2_11, 2'b11, 32'h200);
        check("raw_ready_hold", in_ready_o, 1'b0);
        step();
        check("raw_g1_valid", out_valid_o, 1'b1);
        check("raw_g1_mask", out_lane_valid_o, 2'b01);
        check("raw_g1_split", out_split_o, 1'b1);
        check("raw_g1_ctrl1", ctrl_lane(1), c_nop);
        check("raw_g1_pc0", pc_lane(0), 32'h200);
        step();
        check("raw_g2_mask", out_lane_valid_o, 2'b10);
        check("raw_g2_split", out_split_o, 1'b0);
        check("raw_g2_ctrl1", ctrl_lane(1), c_add);
        check("raw_g2_regs1", regs_lane(1), {5'd2, 5'd1, 5'd1});
        check("raw_g2_pc1", pc_lane(1), 32'h204);
        check("raw_g2_ready", in_ready_o, 1'b1);
        step();
        check("raw_drain", out_valid_o, 1'b0);

        // Writes to x0 never create a hazard.
        send(ADDI_X0, ADD_X2_00, 2'b11, 32'h300);
        step();
        check("x0_mask", out_lane_valid_o, 2'b11);
        check("x0_split", out_split_o, 1'b0);
        step();

        // Two loads cannot share a group.
        send(LW_X1, LW_X3, 2'b11, 32'h400);
        check("mem_ready_hold", in_ready_o, 1'b0);
        step();
        check("mem_g1_mask", out_lane_valid_o, 2'b01);
        check("mem_g1_split", out_split_o, 1'b1);
        check("mem_g1_ctrl0", ctrl_lane(0), c_lw);
        step();
        check("mem_g2_mask", out_lane_valid_o, 2'b10);
        check("mem_g2_split", out_split_o, 1'b0);
        check("mem_g2_ctrl1", ctrl_lane(1), c_lw);
        step();

        // Backpressure holds group 1 for three cycles.
        out_ready_i = 1'b0;
        send(ADDI_X1, ADD_X2_11, 2'b11, 32'h500);
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_valid", out_valid_o, 1'b1);
            check("bp_mask", out_lane_valid_o, 2'b01);
            check("bp_split", out_split_o, 1'b1);
            check("bp_ctrl0", ctrl_lane(0), c_addi);
            check("bp_pc0", pc_lane(0), 32'h500);
            check("bp_ready", in_ready_o, 1'b0);
        end
        out_ready_i = 1'b1;
        step();
        check("bp_g2_mask", out_lane_valid_o, 2'b10);
        check("bp_g2_split", out_split_o, 1'b0);
        check("bp_g2_pc1", pc_lane(1), 32'h504);
        step();
        check("bp_drain", out_valid_o, 1'b0);

        // Flush while group 1 is on the output.
        send(ADDI_X1, ADD_X2_11, 2'b11, 32'h600);
        step();
        check("fl_g1_mask", out_lane_valid_o, 2'b01);
        flush_i = 1'b1;
        #1;
        check("fl_ready_during", in_ready_o, 1'b0);
        step();
        flush_i = 1'b0;
        #1;
        check("fl_valid", out_valid_o, 1'b0);
        check("fl_ready", in_ready_o, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            check("fl_no_lane1", out_valid_o, 1'b0);
        end

        // Asynchronous reset between edges.
        send(ADDI_X1, ADD_X2_34, 2'b11, 32'h700);
        step();
        check("ar_valid_before", out_valid_o, 1'b1);
        #2;
        rstn_i = 1'b0;
        #1;
        check("ar_valid", out_valid_o, 1'b0);
        check("ar_mask", out_lane_valid_o, 2'b00);
        check("ar_ctrl0", ctrl_lane(0), c_nop);
        check("ar_regs", out_regs_o, '0);
        check("ar_pc", out_pc_o, '0);
        #3;
        rstn_i = 1'b1;
        send(ADD_X2_34, ADDI_X1, 2'b11, 32'h800);
        check("ar2_valid_e1", out_valid_o, 1'b0);
        step();
        check("ar2_valid", out_valid_o, 1'b1);
        check("ar2_mask", out_lane_valid_o, 2'b11);
        check("ar2_ctrl0", ctrl_lane(0), c_add);
        check("ar2_ctrl1", ctrl_lane(1), c_addi);
        check("ar2_pc1", pc_lane(1), 32'h804);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
